// File: rtl/simd_fetch_loop_pkg.sv
// Shared ISA constants for the SIMD fetch/loop stage: opcode encodings, field widths,
// and the opcode classifier used by fetch (decode/execute import the same package).
package simd_fetch_loop_pkg;

  localparam int IW_DEF  = 18;
  localparam int AW_DEF  = 10;
  localparam int OPW_DEF = 6;

  localparam logic [OPW_DEF-1:0] OP_SETLOOP  = 6'b100101;
  localparam logic [OPW_DEF-1:0] OP_LOOPJUMP = 6'b100100;
  localparam logic [OPW_DEF-1:0] OP_HALT     = 6'b111111;

  typedef enum logic [1:0] {
    K_OTHER,
    K_SETLOOP,
    K_LOOPJUMP,
    K_HALT
  } op_kind_e;

  function automatic op_kind_e classify(input logic [OPW_DEF-1:0] op);
    case (op)
      OP_SETLOOP:  return K_SETLOOP;
      OP_LOOPJUMP: return K_LOOPJUMP;
      OP_HALT:     return K_HALT;
      default:     return K_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/simd_loop_ctrl.sv
// Hardware loop counter: loaded by setloop, tested and decremented by loopjump.
// take_jump is combinational so the fetch stage can redirect in the same cycle.
module simd_loop_ctrl #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          test,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] count,
  output logic          take_jump
);

  assign take_jump = test && (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            count <= '0;
    else if (load)      count <= load_val;
    else if (take_jump) count <= count - AW'(1);
  end

endmodule

// File: rtl/simd_fetch_loop.sv
// Instruction fetch and loop control: runs setloop/loopjump/halt locally and forwards
// every other instruction to decode through a registered output.
import simd_fetch_loop_pkg::*;

module simd_fetch_loop #(
  parameter int IW       = IW_DEF,
  parameter int AW       = AW_DEF,
  parameter int OPW      = OPW_DEF,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instruction_in,
  output logic [AW-1:0] instruction_address,
  input  logic          ex_stall,
  input  logic          ex_busy,
  output logic [IW-1:0] inst_out,
  output logic          inst_valid,
  output logic [AW-1:0] inst_pc,
  output logic [AW-1:0] loop_count,
  output logic          done
);

  logic [AW-1:0] pc, pc_next, imm;
  logic          fv, halted, consume, take_jump;
  op_kind_e      kind;
  logic          unused_bits;

  assign instruction_address = pc;
  assign kind        = classify(instruction_in[IW-1 -: OPW]);
  assign imm         = instruction_in[AW-1:0];
  assign unused_bits = ^instruction_in[IW-OPW-1:AW];
  // fv masks the first post-reset cycle, before memory has returned a word for RESET_PC
  assign consume     = fv && !halted && !ex_stall;

  simd_loop_ctrl #(.AW(AW)) u_loop (
    .clk       (clk),
    .rst       (rst),
    .load      (consume && kind == K_SETLOOP),
    .test      (consume && kind == K_LOOPJUMP),
    .load_val  (imm),
    .count     (loop_count),
    .take_jump (take_jump)
  );

  always_comb begin
    pc_next = pc;
    if (consume) begin
      case (kind)
        K_HALT:     pc_next = pc;
        K_LOOPJUMP: pc_next = take_jump ? imm : pc + AW'(1);
        default:    pc_next = pc + AW'(1);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= AW'(RESET_PC);
      inst_out   <= '0;
      inst_valid <= 1'b0;
      inst_pc    <= '0;
      fv         <= 1'b0;
      halted     <= 1'b0;
      done       <= 1'b0;
    end else begin
      fv         <= 1'b1;
      pc         <= pc_next;
      inst_valid <= 1'b0;
      if (consume && kind == K_OTHER) begin
        inst_out   <= instruction_in;
        inst_pc    <= pc;
        inst_valid <= 1'b1;
      end
      if (consume && kind == K_HALT) halted <= 1'b1;
      if (halted && !ex_busy)        done   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_simd_fetch_loop.sv
// Scoreboard bench for simd_fetch_loop: a behavioural instruction memory feeds the DUT,
// expected {pc, word, loop_count} tuples are queued per program and popped on inst_valid.
module tb_simd_fetch_loop;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] instruction_in;
  logic [9:0]  instruction_address;
  logic        ex_stall = 1'b0;
  logic        ex_busy = 1'b0;
  logic [17:0] inst_out;
  logic        inst_valid;
  logic [9:0]  inst_pc;
  logic [9:0]  loop_count;
  logic        done;

  simd_fetch_loop dut (
    .clk                 (clk),
    .rst                 (rst),
    .instruction_in      (instruction_in),
    .instruction_address (instruction_address),
    .ex_stall            (ex_stall),
    .ex_busy             (ex_busy),
    .inst_out            (inst_out),
    .inst_valid          (inst_valid),
    .inst_pc             (inst_pc),
    .loop_count          (loop_count),
    .done                (done)
  );

  always #5 clk = ~clk;

  logic [17:0] mem [0:1023];
  always @(negedge clk) instruction_in <= mem[instruction_address];

  typedef struct {
    logic [9:0]  pc;
    logic [17:0] w;
    logic [9:0]  lc;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  localparam logic [17:0] HALTW = {6'b111111, 12'h000};

  function automatic logic [17:0] alu(input int n);
    return {6'b000001, 12'(n)};
  endfunction
  function automatic logic [17:0] setl(input int n);
    return {6'b100101, 2'b00, 10'(n)};
  endfunction
  function automatic logic [17:0] ljmp(input int t);
    return {6'b100100, 2'b00, 10'(t)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = HALTW;
    sbq.delete();
  endtask

  task automatic push(input int pc, input int lc);
    sbq.push_back('{pc: 10'(pc), w: mem[pc], lc: 10'(lc)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ex_stall = 1'b0; ex_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = alu(12'h011);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (instruction_address !== 10'd0 || inst_valid !== 1'b0 || done !== 1'b0 || loop_count !== 10'd0) begin
        bad++;
        $display("FAIL reset_state addr=%0d valid=%b done=%b lc=%0d want 0 0 0 0",
                 instruction_address, inst_valid, done, loop_count);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b0) begin
      bad++; $display("FAIL reset_first_cycle valid=%b want 0", inst_valid);
    end
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b1 || inst_pc !== 10'd0 || inst_out !== mem[0]) begin
      bad++;
      $display("FAIL reset_first_fetch valid=%b pc=%0d out=%h want 1 0 %h", inst_valid, inst_pc, inst_out, mem[0]);
    end
  endtask

  task automatic test_straight();
    int first, last, nvalid;
    exp_t e;
    clear_mem();
    for (int i = 0; i < 4; i++) begin mem[i] = alu(12'h100 + i); push(i, 0); end
    do_reset();
    first = -1; last = -1; nvalid = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (inst_valid) begin
        nvalid++; last = cyc;
        if (first < 0) first = cyc;
        total++;
        if (sbq.size() == 0) begin
          bad++; $display("FAIL straight_extra pc=%0d", inst_pc);
        end else begin
          e = sbq.pop_front();
          if (inst_pc !== e.pc || inst_out !== e.w) begin
            bad++; $display("FAIL straight_item pc=%0d out=%h want %0d %h", inst_pc, inst_out, e.pc, e.w);
          end
        end
      end
    end
    total++;
    if (nvalid != 4 || last - first != 3 || sbq.size() != 0) begin
      bad++; $display("FAIL straight_consecutive n=%0d span=%0d left=%0d want 4 3 0", nvalid, last - first, sbq.size());
    end
  endtask

  task automatic test_loop();
    exp_t e;
    clear_mem();
    for (int i = 0; i < 15; i++) begin mem[i] = alu(12'h020 + i); push(i, 0); end
    mem[15] = setl(2);
    mem[16] = alu(12'h216);
    mem[17] = alu(12'h217);
    mem[18] = ljmp(16);
    mem[19] = alu(12'h219);
    for (int it = 0; it < 3; it++) begin push(16, 2 - it); push(17, 2 - it); end
    push(19, 0);
    do_reset();
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (inst_valid) begin
        total++;
        if (sbq.size() == 0) begin
          bad++; $display("FAIL loop_extra pc=%0d out=%h", inst_pc, inst_out);
        end else begin
          e = sbq.pop_front();
          if (inst_pc !== e.pc || inst_out !== e.w || loop_count !== e.lc) begin
            bad++;
            $display("FAIL loop_item pc=%0d out=%h lc=%0d want %0d %h %0d",
                     inst_pc, inst_out, loop_count, e.pc, e.w, e.lc);
          end
        end
      end
    end
    total++;
    if (sbq.size() != 0 || instruction_address !== 10'd20) begin
      bad++; $display("FAIL loop_end left=%0d addr=%0d want 0 20", sbq.size(), instruction_address);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int stall_left;
    bit stalled;
    clear_mem();
    for (int i = 0; i < 8; i++) begin mem[i] = alu(12'h040 + i); push(i, 0); end
    do_reset();
    stall_left = 0; stalled = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (stall_left > 0) begin
        total++;
        if (instruction_address !== 10'd5 || inst_valid !== 1'b0) begin
          bad++; $display("FAIL stall_hold addr=%0d valid=%b want 5 0", instruction_address, inst_valid);
        end
        stall_left--;
        if (stall_left == 0) ex_stall = 1'b0;
      end else begin
        if (inst_valid) begin
          total++;
          if (sbq.size() == 0) begin
            bad++; $display("FAIL stall_extra pc=%0d", inst_pc);
          end else begin
            e = sbq.pop_front();
            if (inst_pc !== e.pc || inst_out !== e.w) begin
              bad++; $display("FAIL stall_item pc=%0d out=%h want %0d %h", inst_pc, inst_out, e.pc, e.w);
            end
          end
        end
        if (!stalled && instruction_address == 10'd5) begin
          ex_stall = 1'b1; stall_left = 3; stalled = 1;
        end
      end
    end
    total++;
    if (!stalled || sbq.size() != 0) begin
      bad++; $display("FAIL stall_end stalled=%0d left=%0d want 1 0", stalled, sbq.size());
    end
  endtask

  task automatic test_halt();
    clear_mem();
    mem[0] = setl(1);
    mem[1] = ljmp(20);
    do_reset();
    ex_busy = 1'b1;
    repeat (6) begin
      @(negedge clk);
      total++;
      if (inst_valid !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL halt_busy valid=%b done=%b want 0 0", inst_valid, done);
      end
    end
    total++;
    if (instruction_address !== 10'd20) begin
      bad++; $display("FAIL halt_addr addr=%0d want 20", instruction_address);
    end
    ex_busy = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL halt_done done=%b want 1", done);
    end
    ex_busy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (done !== 1'b1 || instruction_address !== 10'd20 || inst_valid !== 1'b0) begin
        bad++; $display("FAIL halt_sticky done=%b addr=%0d valid=%b want 1 20 0", done, instruction_address, inst_valid);
      end
    end
    ex_busy = 1'b0;
  endtask

  task automatic test_async_rst();
    exp_t e;
    bit hit;
    clear_mem();
    mem[0] = setl(1);
    mem[1] = alu(12'h055);
    mem[2] = ljmp(1);
    push(1, 1); push(1, 0);
    do_reset();
    hit = 0;
    for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
      @(negedge clk);
      if (inst_valid && loop_count == 10'd1) hit = 1;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL arst_reach loop_count=%0d want 1 with valid", loop_count);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (instruction_address !== 10'd0 || inst_valid !== 1'b0 || loop_count !== 10'd0 ||
        inst_out !== 18'd0 || inst_pc !== 10'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL arst_immediate addr=%0d valid=%b lc=%0d out=%h pc=%0d done=%b want all 0",
               instruction_address, inst_valid, loop_count, inst_out, inst_pc, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (loop_count !== 10'd0 || instruction_address !== 10'd0) begin
      bad++; $display("FAIL arst_restart lc=%0d addr=%0d want 0 0", loop_count, instruction_address);
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (inst_valid) begin
        total++;
        if (sbq.size() == 0) begin
          bad++; $display("FAIL arst_extra pc=%0d", inst_pc);
        end else begin
          e = sbq.pop_front();
          if (inst_pc !== e.pc || inst_out !== e.w || loop_count !== e.lc) begin
            bad++;
            $display("FAIL arst_item pc=%0d out=%h lc=%0d want %0d %h %0d", inst_pc, inst_out, loop_count, e.pc, e.w, e.lc);
          end
        end
      end
    end
    total++;
    if (sbq.size() != 0) begin
      bad++; $display("FAIL arst_left left=%0d want 0", sbq.size());
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    bit seen;
    // ALU op at the top of memory: PC wraps to 0
    clear_mem();
    mem[0] = setl(1);
    mem[1] = ljmp(1023);
    mem[1023] = alu(12'h3ff);
    push(1023, 0);
    do_reset();
    seen = 0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      if (inst_valid) begin
        seen = 1;
        e = sbq.pop_front();
        total++;
        if (inst_pc !== e.pc || inst_out !== e.w || instruction_address !== 10'd0) begin
          bad++;
          $display("FAIL wrap_alu pc=%0d out=%h addr=%0d want %0d %h 0", inst_pc, inst_out, instruction_address, e.pc, e.w);
        end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL wrap_alu_timeout seen=0 want 1"); end
    // loopjump at the top with count 0 falls through to 0
    clear_mem();
    mem[0] = setl(1);
    mem[1] = ljmp(1022);
    mem[1022] = alu(12'h3fe);
    mem[1023] = ljmp(700);
    push(1022, 0);
    do_reset();
    seen = 0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      if (inst_valid) begin
        seen = 1;
        e = sbq.pop_front();
        total++;
        if (inst_pc !== e.pc || inst_out !== e.w || instruction_address !== 10'd1023) begin
          bad++;
          $display("FAIL wrap_pre pc=%0d out=%h addr=%0d want %0d %h 1023", inst_pc, inst_out, instruction_address, e.pc, e.w);
        end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL wrap_jump_timeout seen=0 want 1"); end
    @(negedge clk);
    total++;
    if (instruction_address !== 10'd0 || inst_valid !== 1'b0 || loop_count !== 10'd0) begin
      bad++;
      $display("FAIL wrap_fallthrough addr=%0d valid=%b lc=%0d want 0 0 0", instruction_address, inst_valid, loop_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_straight();
    test_loop();
    test_stall();
    test_halt();
    test_async_rst();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
